// File: rtl/uart_pkg.sv
// Shared UART bridge definitions: receiver FSM states, register offsets,
// AXI response codes and status bit positions.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

  localparam logic [2:0] RX_DATA_OFS = 3'h0;
  localparam logic [2:0] RX_STAT_OFS = 3'h4;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  localparam int STAT_NEMPTY     = 0;
  localparam int STAT_OVERRUN    = 1;
  localparam int STAT_FRAME_ERR  = 2;
  localparam int STAT_FULL       = 3;
  localparam int STAT_PARITY_ERR = 4;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte-wide synchronous FIFO; pointers carry one extra wrap bit so that
// full and empty are distinguishable.
module uart_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wp, rp;
  logic        do_push, do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot, so a push into a full FIFO is allowed then
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/axi4_uart_rx_bridge.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a byte FIFO,
// read back through a single-beat AXI4 read responder (data + status regs).
module axi4_uart_rx_bridge
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 104,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h9000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  input  logic        axi_arvalid,
  input  logic [31:0] axi_araddr,
  input  logic [3:0]  axi_arid,
  output logic        axi_arready,
  output logic        axi_rvalid,
  input  logic        axi_rready,
  output logic [31:0] axi_rdata,
  output logic [1:0]  axi_rresp,
  output logic        axi_rlast,
  output logic [3:0]  axi_rid,
  output logic        rx_irq,
  output logic        uart_rx_active
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic          rx_s1, rx_sync, rx_prev;
  rx_state_e     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          push_q, frame_evt;
  logic          fifo_full, fifo_empty, fifo_pop;
  logic [7:0]    fifo_head;
  logic          frame_err, overrun, overrun_evt;
  logic          ar_hs, hit, sel_data, sel_stat;
  logic [31:0]   status;
  logic          unused_addr;
`ifdef UART_RX_PARITY_EN
  logic          par_bad, par_evt, parity_err;
`endif

  assign unused_addr = ^axi_araddr[1:0];

  // Sync flops preset high so reset never looks like a start edge
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_sync <= rx_s1;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      push_q    <= 1'b0;
      frame_evt <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
      par_evt   <= 1'b0;
`endif
    end else begin
      push_q    <= 1'b0;
      frame_evt <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_evt   <= 1'b0;
`endif
      case (state)
        IDLE: if (rx_prev && !rx_sync) begin
          cnt   <= '0;
          state <= START;
        end
        START: if (cnt == HALF) begin
          cnt     <= '0;
          bit_idx <= '0;
          state   <= rx_sync ? IDLE : DATA;
        end else cnt <= cnt + 1'b1;
        DATA: if (cnt == LAST) begin
          cnt     <= '0;
          shreg   <= {rx_sync, shreg[7:1]};
          bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == 3'd7) state <= PARITY;
`else
          if (bit_idx == 3'd7) state <= STOP;
`endif
        end else cnt <= cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
        PARITY: if (cnt == LAST) begin
          cnt     <= '0;
          par_bad <= ^{shreg, rx_sync};
          state   <= STOP;
        end else cnt <= cnt + 1'b1;
`endif
        STOP: if (cnt == LAST) begin
          cnt   <= '0;
          state <= IDLE;
          if (!rx_sync) frame_evt <= 1'b1;
`ifdef UART_RX_PARITY_EN
          else if (par_bad) par_evt <= 1'b1;
`endif
          else push_q <= 1'b1;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  assign uart_rx_active = (state != IDLE);

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .wdata (shreg),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  assign rx_irq      = !fifo_empty;
  assign axi_arready = !axi_rvalid;
  assign axi_rlast   = 1'b1;
  assign ar_hs       = axi_arvalid && axi_arready;
  assign hit         = (axi_araddr[31:3] == BASE_ADDR[31:3]);
  assign sel_data    = hit && (axi_araddr[2] == RX_DATA_OFS[2]);
  assign sel_stat    = hit && (axi_araddr[2] == RX_STAT_OFS[2]);
  assign fifo_pop    = ar_hs && sel_data && !fifo_empty;
  assign overrun_evt = push_q && fifo_full && !fifo_pop;

  always_comb begin
    status                 = '0;
    status[STAT_NEMPTY]    = !fifo_empty;
    status[STAT_OVERRUN]   = overrun;
    status[STAT_FRAME_ERR] = frame_err;
    status[STAT_FULL]      = fifo_full;
`ifdef UART_RX_PARITY_EN
    status[STAT_PARITY_ERR] = parity_err;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      axi_rvalid <= 1'b0;
      axi_rdata  <= '0;
      axi_rresp  <= OKAY;
      axi_rid    <= '0;
    end else if (ar_hs) begin
      axi_rvalid <= 1'b1;
      axi_rid    <= axi_arid;
      if (sel_data) begin
        axi_rdata <= fifo_empty ? 32'h0 : {24'h0, fifo_head};
        axi_rresp <= OKAY;
      end else if (sel_stat) begin
        axi_rdata <= status;
        axi_rresp <= OKAY;
      end else begin
        axi_rdata <= '0;
        axi_rresp <= SLVERR;
      end
    end else if (axi_rvalid && axi_rready) begin
      axi_rvalid <= 1'b0;
    end
  end

  // Sticky flags clear on a status read; a same-cycle error event wins
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err  <= (frame_err && !(ar_hs && sel_stat)) || frame_evt;
      overrun    <= (overrun && !(ar_hs && sel_stat)) || overrun_evt;
`ifdef UART_RX_PARITY_EN
      parity_err <= (parity_err && !(ar_hs && sel_stat)) || par_evt;
`endif
    end
  end

endmodule

// File: tb/tb_axi4_uart_rx_bridge.sv
// Directed bench for axi4_uart_rx_bridge: serial frames in, AXI reads out.
module tb_axi4_uart_rx_bridge;
  localparam int CPB = 104;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_rx;
  logic        axi_arvalid;
  logic [31:0] axi_araddr;
  logic [3:0]  axi_arid;
  logic        axi_arready;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast;
  logic [3:0]  axi_rid;
  logic        rx_irq;
  logic        uart_rx_active;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi4_uart_rx_bridge #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (8),
    .BASE_ADDR    (32'h9000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .uart_rx        (uart_rx),
    .axi_arvalid    (axi_arvalid),
    .axi_araddr     (axi_araddr),
    .axi_arid       (axi_arid),
    .axi_arready    (axi_arready),
    .axi_rvalid     (axi_rvalid),
    .axi_rready     (axi_rready),
    .axi_rdata      (axi_rdata),
    .axi_rresp      (axi_rresp),
    .axi_rlast      (axi_rlast),
    .axi_rid        (axi_rid),
    .rx_irq         (rx_irq),
    .uart_rx_active (uart_rx_active)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  // Issue one read; R outputs are checked each cycle rready is held low
  task automatic axi_read(input string nm, input logic [31:0] a, input logic [3:0] id,
                          input int hold, input logic [31:0] exp_d, input logic [1:0] exp_r);
    int n;
    @(negedge clk);
    axi_arvalid = 1'b1;
    axi_araddr  = a;
    axi_arid    = id;
    axi_rready  = (hold == 0);
    n = 0;
    while (!axi_arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " arready"}, axi_arready, 1);
    @(posedge clk); #1;
    axi_arvalid = 1'b0;
    chk({nm, " rvalid"}, axi_rvalid, 1);
    chk({nm, " rdata"}, axi_rdata, exp_d);
    chk({nm, " rresp"}, axi_rresp, exp_r);
    chk({nm, " rid"}, axi_rid, id);
    chk({nm, " rlast"}, axi_rlast, 1);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk({nm, " hold rvalid"}, axi_rvalid, 1);
      chk({nm, " hold rdata"}, axi_rdata, exp_d);
      chk({nm, " hold rresp"}, axi_rresp, exp_r);
      chk({nm, " hold rid"}, axi_rid, id);
      chk({nm, " hold arready"}, axi_arready, 0);
    end
    if (hold > 0) begin
      @(negedge clk);
      axi_rready = 1'b1;
    end
    @(posedge clk); #1;
    axi_rready = 1'b0;
    chk({nm, " rvalid drop"}, axi_rvalid, 0);
    chk({nm, " arready back"}, axi_arready, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; uart_rx = 1'b1;
    axi_arvalid = 1'b0; axi_araddr = '0; axi_arid = '0; axi_rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst arready", axi_arready, 1);
    chk("rst rvalid", axi_rvalid, 0);
    chk("rst rdata", axi_rdata, 0);
    chk("rst rresp", axi_rresp, 0);
    chk("rst rid", axi_rid, 0);
    chk("rst irq", rx_irq, 0);
    chk("rst active", uart_rx_active, 0);
    @(negedge clk); rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single byte round trip
    send_byte(8'h55, 1'b1);
    chk("b55 irq", rx_irq, 1);
    axi_read("b55", 32'h9000_0000, 4'd5, 0, 32'h55, 2'b00);
    chk("b55 irq after pop", rx_irq, 0);

    // Short low glitch must be rejected in START
    @(negedge clk); uart_rx = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch active", uart_rx_active, 1);
    repeat (10) @(negedge clk);
    uart_rx = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch idle", uart_rx_active, 0);
    chk("glitch irq", rx_irq, 0);
    send_byte(8'hA3, 1'b1);
    axi_read("bA3", 32'h9000_0000, 4'd9, 0, 32'hA3, 2'b00);

    // Overfill: 10 bytes into 8 entries, then the read table
    for (int i = 1; i <= 10; i++) send_byte(8'(i), 1'b1);
    vecs[0]  = '{32'h9000_0004, 4'd1, 32'h0000_000B, 2'b00};
    vecs[1]  = '{32'h9000_0004, 4'd2, 32'h0000_0009, 2'b00};
    for (int i = 2; i < 10; i++)
      vecs[i] = '{32'h9000_0000, 4'(i + 1), 32'(i - 1), 2'b00};
    vecs[10] = '{32'h9000_0000, 4'd11, 32'h0, 2'b00};
    vecs[11] = '{32'h9000_0004, 4'd12, 32'h0, 2'b00};
    vecs[12] = '{32'h9000_0008, 4'd13, 32'h0, 2'b10};
    vecs[13] = '{32'h9000_0003, 4'd14, 32'h0, 2'b00};
    vecs[14] = '{32'h9000_0006, 4'd15, 32'h0, 2'b00};
    vecs[15] = '{32'h8000_0000, 4'd0,  32'h0, 2'b10};
    for (int i = 0; i < 16; i++)
      axi_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].id, 0,
               vecs[i].exp_data, vecs[i].exp_resp);

    // Framing error: stop bit low
    send_byte(8'h7E, 1'b0);
    chk("ferr irq", rx_irq, 0);
    axi_read("ferr stat1", 32'h9000_0004, 4'd3, 0, 32'h4, 2'b00);
    axi_read("ferr stat2", 32'h9000_0004, 4'd4, 0, 32'h0, 2'b00);

    // Unmapped address with a stalled R channel
    axi_read("slverr hold", 32'h9000_0010, 4'd7, 5, 32'h0, 2'b10);

    // Reset mid-frame with bytes queued
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    chk("pre-rst irq", rx_irq, 1);
    @(negedge clk); uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1; repeat (CPB) @(negedge clk);
    uart_rx = 1'b0; repeat (CPB) @(negedge clk);
    uart_rx = 1'b1; repeat (CPB / 2) @(negedge clk);
    chk("mid-frame active", uart_rx_active, 1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("post-rst active", uart_rx_active, 0);
    chk("post-rst irq", rx_irq, 0);
    repeat (12 * CPB) @(negedge clk);
    chk("post-rst idle irq", rx_irq, 0);
    axi_read("post-rst stat", 32'h9000_0004, 4'd6, 0, 32'h0, 2'b00);
    axi_read("post-rst data", 32'h9000_0000, 4'd8, 0, 32'h0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
